// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // One nibble per key, index r*4+c, index 0 in bits [3:0]
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic [1:0] {
    CLASS_NONE   = 2'd0,
    CLASS_SINGLE = 2'd1,
    CLASS_MULTI  = 2'd2
  } pass_class_e;

  typedef enum logic {
    ST_DRIVE  = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_e;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [5:0] base;
    base = {r, c, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Pass-level debounce: accepts a press or release once DEBOUNCE_SCANS
// consecutive scan passes agree on class and code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pass_done_i,
  input  pass_class_e class_i,
  input  logic [3:0]  code_i,
  output logic        press_c_o,
  output logic        key_valid_o,
  output logic        key_held_o,
  output logic [3:0]  key_code_o
);

  localparam int unsigned AGREE_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [AGREE_W-1:0] AGREE_MAX = AGREE_W'(DEBOUNCE_SCANS);

  pass_class_e        prev_class_q, prev_class_d;
  logic [3:0]         prev_code_q, prev_code_d;
  logic [AGREE_W-1:0] agree_q, agree_d;
  logic               key_valid_q, key_held_q;
  logic [3:0]         key_code_q;
  logic               match_c, press_c, release_c;

  always_comb begin
    prev_class_d = prev_class_q;
    prev_code_d  = prev_code_q;
    agree_d      = agree_q;
    press_c      = 1'b0;
    release_c    = 1'b0;
    match_c      = (class_i == prev_class_q) && (code_i == prev_code_q);
    if (pass_done_i) begin
      prev_class_d = class_i;
      prev_code_d  = code_i;
      if (!match_c) begin
        agree_d = AGREE_W'(1);
      end else if (agree_q != AGREE_MAX) begin
        agree_d = agree_q + AGREE_W'(1);
      end
      // MULTI falls through both tests, so it never changes the held state
      if (agree_d == AGREE_MAX) begin
        press_c   = (class_i == CLASS_SINGLE) && !key_held_q;
        release_c = (class_i == CLASS_NONE) && key_held_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_class_q <= CLASS_NONE;
      prev_code_q  <= 4'h0;
      agree_q      <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      key_code_q   <= 4'h0;
    end else begin
      prev_class_q <= prev_class_d;
      prev_code_q  <= prev_code_d;
      agree_q      <= agree_d;
      key_valid_q  <= press_c;
      if (press_c) begin
        key_code_q <= code_i;
        key_held_q <= 1'b1;
      end else if (release_c) begin
        key_held_q <= 1'b0;
      end
    end
  end

  assign press_c_o   = press_c;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchronizer, pass classification and
// debounced hex key events. Define KEYPAD_ENTRY_EN to build the entry register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam logic [DWELL_W-1:0] DWELL_PRE = DWELL_W'(SCAN_DIV - 2);

  logic [3:0]         sync1_q, sync2_q;
  scan_state_e        state_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         col_idx_q;
  logic [3:0]         col_q;
  logic [15:0]        acc_q, acc_d;
  logic [4:0]         hits_c;
  logic [1:0]         hit_row_c, hit_col_c;
  pass_class_e        pass_class_c;
  logic [3:0]         pass_code_c;
  logic               pass_done_c;
  logic               press_c;

  // Two-flop synchronizer; idle rows read as released
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  // Accumulator slot c*4+r holds "row r low while column c driven"
  always_comb begin
    acc_d = acc_q;
    acc_d[{col_idx_q, 2'b00} +: 4] = ~sync2_q;
  end

  // Scan FSM: SAMPLE is the last dwell cycle of each column
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_DRIVE;
      dwell_q   <= '0;
      col_idx_q <= 2'd0;
      col_q     <= COL_RESET;
      acc_q     <= '0;
    end else begin
      unique case (state_q)
        ST_DRIVE: begin
          dwell_q <= dwell_q + DWELL_W'(1);
          if (dwell_q == DWELL_PRE) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          acc_q     <= acc_d;
          dwell_q   <= '0;
          col_idx_q <= col_idx_q + 2'd1;
          col_q     <= col_drive(col_idx_q + 2'd1);
          state_q   <= ST_DRIVE;
        end
      endcase
    end
  end

  assign pass_done_c = (state_q == ST_SAMPLE) && (col_idx_q == 2'd3);

  // Classify the completed pass, including the column-3 sample in flight
  always_comb begin
    hits_c    = 5'd0;
    hit_row_c = 2'd0;
    hit_col_c = 2'd0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (acc_d[4'(i)]) begin
        hits_c    = hits_c + 5'd1;
        hit_col_c = 2'(i / 4);
        hit_row_c = 2'(i % 4);
      end
    end
    pass_class_c = CLASS_MULTI;
    pass_code_c  = 4'h0;
    if (hits_c == 5'd0) begin
      pass_class_c = CLASS_NONE;
    end else if (hits_c == 5'd1) begin
      pass_class_c = CLASS_SINGLE;
      pass_code_c  = key_lookup(hit_row_c, hit_col_c);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .pass_done_i(pass_done_c),
    .class_i    (pass_class_c),
    .code_i     (pass_code_c),
    .press_c_o  (press_c),
    .key_valid_o(key_valid),
    .key_held_o (key_held),
    .key_code_o (key_code)
  );

  assign col = col_q;

`ifdef KEYPAD_ENTRY_EN
  logic [15:0] entry_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q <= 16'h0000;
    end else if (press_c) begin
      entry_q <= {entry_q[11:0], pass_code_c};
    end
  end

  assign entry = entry_q;
`else
  assign entry = 16'h0000;
`endif

endmodule
